// File: rtl/sopc_data_bus_if.sv
// Bundle of the core data-side request/response signals and the broadcast
// slave-side bus that sopc_data_bus sits between.
//   slave  : the interconnect's view (it serves the core and drives the slaves)
//   master : the environment's view (core request side plus the slave models)
interface sopc_data_bus_if #(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
);
  // core side
  logic                         i_ce;
  logic                         i_we;
  logic [DATA_W/8-1:0]          i_sel;
  logic [ADDR_W-1:0]            i_addr;
  logic [DATA_W-1:0]            i_wdata;
  logic [DATA_W-1:0]            o_rdata;
  logic                         o_stall;
  logic                         o_bus_err;
  logic [ADDR_W-1:0]            o_err_addr;
  // slave side
  logic [N_SLAVES-1:0]          o_s_ce;
  logic                         o_s_we;
  logic [DATA_W/8-1:0]          o_s_sel;
  logic [ADDR_W-1:0]            o_s_addr;
  logic [DATA_W-1:0]            o_s_wdata;
  logic [N_SLAVES*DATA_W-1:0]   i_s_rdata;
  logic [N_SLAVES-1:0]          i_s_ack;

  modport slave (
    input  i_ce, i_we, i_sel, i_addr, i_wdata, i_s_rdata, i_s_ack,
    output o_rdata, o_stall, o_bus_err, o_err_addr,
           o_s_ce, o_s_we, o_s_sel, o_s_addr, o_s_wdata
  );

  modport master (
    output i_ce, i_we, i_sel, i_addr, i_wdata, i_s_rdata, i_s_ack,
    input  o_rdata, o_stall, o_bus_err, o_err_addr,
           o_s_ce, o_s_we, o_s_sel, o_s_addr, o_s_wdata
  );
endinterface

// File: rtl/sopc_data_bus.sv
// sopc_data_bus: data-side interconnect between the core data port and
// N_SLAVES memory-mapped slaves. Decodes addr[SEL_MSB:SEL_LSB] to a slave
// index, registers the request onto a broadcast bus with a one-hot chip
// enable, stalls the core until the selected slave acks, and flags accesses
// to unmapped indices as a one-cycle bus error.
//
// Optional build macro SOPC_DATA_BUS_TIMEOUT_EN: abandons an access after
// TIMEOUT cycles without ack and reports it as a bus error (read data 0).
// Without it, an access waits for its ack indefinitely.
module sopc_data_bus #(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SEL_MSB  = 31,
  parameter int SEL_LSB  = 28,
  parameter int TIMEOUT  = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  sopc_data_bus_if.slave bus
);

  localparam int SW = SEL_MSB - SEL_LSB + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [SW-1:0]       req_idx;
  logic [N_SLAVES-1:0] ce_dec;
  logic                req_hit;
  logic                ack_hit;
  logic [DATA_W-1:0]   sel_rdata;
  logic                tmo_hit;

  // Address decode: one-hot enable for the addressed slave, all-zero when
  // the index falls outside the populated slave range.
  always_comb begin
    req_idx = bus.i_addr[SEL_MSB:SEL_LSB];
    ce_dec  = '0;
    for (int k = 0; k < N_SLAVES; k++)
      ce_dec[k] = (req_idx == SW'(k));
    req_hit = |ce_dec;
  end

  // Return path: only the selected slave's ack and read data are looked at,
  // so strays from other slaves cannot complete or corrupt the access.
  always_comb begin
    ack_hit   = |(bus.o_s_ce & bus.i_s_ack);
    sel_rdata = '0;
    for (int k = 0; k < N_SLAVES; k++)
      if (bus.o_s_ce[k])
        sel_rdata = sel_rdata | bus.i_s_rdata[k*DATA_W +: DATA_W];
  end

`ifdef SOPC_DATA_BUS_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] tmo_cnt;

  // Wait-cycle counter: zero on ACCESS entry, counts ACCESS cycles without ack.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || state != ACCESS)
      tmo_cnt <= '0;
    else if (!ack_hit)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Expiry in the same cycle as an ack loses to the ack.
  assign tmo_hit = (state == ACCESS) && !ack_hit && (tmo_cnt == CW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic. DONE always returns to IDLE so the still-asserted
  // i_ce of the completed request is not taken as a new one.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_ce) state_nxt = req_hit ? ACCESS : DONE;
      ACCESS:  if (ack_hit || tmo_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall output: the request cycle and every ACCESS cycle hold the core.
  always_comb begin
    bus.o_stall = ((state == IDLE) && bus.i_ce) || (state == ACCESS);
  end

  // Request capture, chip-enable, read-data and error registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bus.o_s_ce     <= '0;
      bus.o_s_we     <= 1'b0;
      bus.o_s_sel    <= '0;
      bus.o_s_addr   <= '0;
      bus.o_s_wdata  <= '0;
      bus.o_rdata    <= '0;
      bus.o_bus_err  <= 1'b0;
      bus.o_err_addr <= '0;
    end else begin
      // error is a pulse that lives only in DONE
      bus.o_bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_ce) begin
            bus.o_s_we    <= bus.i_we;
            bus.o_s_sel   <= bus.i_sel;
            bus.o_s_addr  <= bus.i_addr;
            bus.o_s_wdata <= bus.i_wdata;
            bus.o_s_ce    <= ce_dec;
            if (!req_hit) begin
              bus.o_bus_err  <= 1'b1;
              bus.o_err_addr <= bus.i_addr;
            end
          end
        end
        ACCESS: begin
          if (ack_hit) begin
            bus.o_s_ce <= '0;
            if (!bus.o_s_we) bus.o_rdata <= sel_rdata;
          end else if (tmo_hit) begin
            bus.o_s_ce     <= '0;
            bus.o_bus_err  <= 1'b1;
            bus.o_err_addr <= bus.o_s_addr;
            if (!bus.o_s_we) bus.o_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sopc_data_bus.sv
// Directed bench for sopc_data_bus: reads, writes with wait states, an
// unmapped access, stray acks, reset mid-access and the never-ack case.
module tb_sopc_data_bus;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  always #5 i_clk = ~i_clk;

  sopc_data_bus_if #(.N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sopc_data_bus #(
    .N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW),
    .SEL_MSB(31), .SEL_LSB(28), .TIMEOUT(16)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  int n_err = 0;
  int n_chk = 0;

  // results of the last transaction
  int          r_stall;
  int          r_ce;
  logic [3:0]  r_ce_seen;
  logic        r_bcast_ok;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_rdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Issue one request right after a posedge and act as the slave: the slave
  // named by addr[29:28] acks in ACCESS cycle 'waits'; 'stray' (if >= 0)
  // pulses an ack in ACCESS cycle 0. Observes until the stall drops (DONE)
  // or 'limit' cycles pass, then releases i_ce after the next edge.
  task automatic run(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                     input logic [31:0] wdata, input int waits, input int stray,
                     input int limit);
    int a;
    logic [1:0] k;
    a = 0;
    k = addr[29:28];
    bus.i_ce    = 1'b1;
    bus.i_we    = we;
    bus.i_sel   = sel;
    bus.i_addr  = addr;
    bus.i_wdata = wdata;
    r_stall = 0; r_ce = 0; r_ce_seen = '0; r_bcast_ok = 1'b1;
    r_done = 1'b0; r_err = 1'b0; r_rdata = '0;
    for (int c = 0; c < limit; c++) begin
      @(negedge i_clk);
      if (bus.o_stall === 1'b0) begin
        r_done  = 1'b1;
        r_err   = bus.o_bus_err;
        r_rdata = bus.o_rdata;
        break;
      end
      r_stall++;
      bus.i_s_ack = '0;
      if (bus.o_s_ce != '0) begin
        r_ce++;
        r_ce_seen = r_ce_seen | bus.o_s_ce;
        if (bus.o_s_we !== we || bus.o_s_sel !== sel ||
            bus.o_s_addr !== addr || bus.o_s_wdata !== wdata)
          r_bcast_ok = 1'b0;
        if (a == waits) bus.i_s_ack[k] = 1'b1;
        if (a == 0 && stray >= 0) bus.i_s_ack[stray] = 1'b1;
        a++;
      end
    end
    @(posedge i_clk); #1;
    bus.i_ce    = 1'b0;
    bus.i_s_ack = '0;
  endtask

  initial begin
    bus.i_ce      = 1'b0;
    bus.i_we      = 1'b0;
    bus.i_sel     = '0;
    bus.i_addr    = '0;
    bus.i_wdata   = '0;
    bus.i_s_ack   = '0;
    bus.i_s_rdata = {32'hDEAD_0003, 32'h0BAD_0002, 32'hCAFE_0001, 32'h1234_5678};

    // reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_rdata",   bus.o_rdata,    0);
    chk("rst_s_ce",    bus.o_s_ce,     0);
    chk("rst_bus_err", bus.o_bus_err,  0);
    chk("rst_err_adr", bus.o_err_addr, 0);
    chk("rst_stall",   bus.o_stall,    0);
    chk("rst_s_addr",  bus.o_s_addr,   0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // read slave 0, immediate ack
    run(1'b0, 4'hF, 32'h0000_0010, 32'h0, 0, -1, 50);
    chk("rd0_done",  r_done,    1);
    chk("rd0_stall", r_stall,   2);
    chk("rd0_ce_n",  r_ce,      1);
    chk("rd0_ce",    r_ce_seen, 4'b0001);
    chk("rd0_rdata", r_rdata,   32'h1234_5678);
    chk("rd0_err",   r_err,     0);

    // write slave 2, three wait cycles (back-to-back with previous)
    run(1'b1, 4'b0011, 32'h2000_0004, 32'hAABB_CCDD, 3, -1, 50);
    chk("wr2_done",  r_done,     1);
    chk("wr2_stall", r_stall,    5);
    chk("wr2_ce_n",  r_ce,       4);
    chk("wr2_ce",    r_ce_seen,  4'b0100);
    chk("wr2_bcast", r_bcast_ok, 1);
    chk("wr2_rdata", r_rdata,    32'h1234_5678);
    chk("wr2_err",   r_err,      0);

    // unmapped index 5
    run(1'b0, 4'hF, 32'h5000_0000, 32'h0, 0, -1, 50);
    chk("err_done",  r_done,  1);
    chk("err_stall", r_stall, 1);
    chk("err_ce_n",  r_ce,    0);
    chk("err_flag",  r_err,   1);
    chk("err_rdata", r_rdata, 32'h1234_5678);
    chk("err_addr",  bus.o_err_addr, 32'h5000_0000);
    chk("err_pulse", bus.o_bus_err,  0);

    // stray ack from slave 3 during a slave-1 read, real ack two cycles later
    run(1'b0, 4'hF, 32'h1000_0008, 32'h0, 2, 3, 50);
    chk("stray_done",  r_done,    1);
    chk("stray_stall", r_stall,   4);
    chk("stray_ce_n",  r_ce,      3);
    chk("stray_ce",    r_ce_seen, 4'b0010);
    chk("stray_rdata", r_rdata,   32'hCAFE_0001);
    chk("stray_err",   r_err,     0);
    chk("err_addr_hold", bus.o_err_addr, 32'h5000_0000);

    // reset while in ACCESS to slave 1
    bus.i_ce   = 1'b1;
    bus.i_we   = 1'b0;
    bus.i_addr = 32'h1000_0000;
    @(posedge i_clk); #1;
    bus.i_ce = 1'b0;
    chk("mid_ce", bus.o_s_ce, 4'b0010);
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    chk("mid_rst_ce",    bus.o_s_ce,     0);
    chk("mid_rst_rdata", bus.o_rdata,    0);
    chk("mid_rst_err",   bus.o_bus_err,  0);
    chk("mid_rst_stall", bus.o_stall,    0);
    chk("mid_rst_eaddr", bus.o_err_addr, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // fresh request after reset, one wait cycle
    run(1'b0, 4'hF, 32'h0000_0020, 32'h0, 1, -1, 50);
    chk("post_done",  r_done,  1);
    chk("post_stall", r_stall, 3);
    chk("post_rdata", r_rdata, 32'h1234_5678);

    // slave 3 never acks
    run(1'b0, 4'hF, 32'h3000_0000, 32'h0, 1000, -1, 40);
`ifdef SOPC_DATA_BUS_TIMEOUT_EN
    chk("tmo_done",  r_done,  1);
    chk("tmo_stall", r_stall, 17);
    chk("tmo_ce_n",  r_ce,    16);
    chk("tmo_err",   r_err,   1);
    chk("tmo_rdata", r_rdata, 0);
    chk("tmo_eaddr", bus.o_err_addr, 32'h3000_0000);
`else
    chk("hang_done",  r_done,  0);
    chk("hang_stall", r_stall, 40);
    chk("hang_still", bus.o_stall,   1);
    chk("hang_err",   bus.o_bus_err, 0);
    chk("hang_ce",    bus.o_s_ce,    4'b1000);
`endif
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    chk("final_ce", bus.o_s_ce, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sopc_data_bus.md
Name: sopc_data_bus

Overview:
- Parametrised data-side interconnect between the openmips core data port and N_SLAVES memory-mapped slaves (data_ram, timer, GPIO, ...).
- Replaces the single point-to-point core-to-data_ram connection:
  - decodes the upper address bits to a slave index;
  - registers the request and drives a one-hot slave chip-enable;
  - waits for a per-slave ack and stalls the core until completion;
  - flags unmapped accesses as bus errors.

Parameters:
- N_SLAVES, 4, number of slave ports (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8).
- SEL_MSB, 31, MSB of the slave-index field in the address.
- SEL_LSB, 28, LSB of the slave-index field; field width SEL_MSB-SEL_LSB+1 must be >= clog2(N_SLAVES).
- TIMEOUT, 16, cycles in ACCESS without ack before a bus error (used only with the optional feature).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_ce  in  1  core data request
- i_we  in  1  1=write, 0=read
- i_sel  in  DATA_W/8  byte enables
- i_addr  in  ADDR_W  byte address
- i_wdata  in  DATA_W  write data
- o_rdata  out  DATA_W  read data, registered
- o_stall  out  1  core pipeline stall request
- o_bus_err  out  1  one-cycle error pulse
- o_err_addr  out  ADDR_W  address of the last errored access
- o_s_ce  out  N_SLAVES  one-hot slave chip-enable
- o_s_we  out  1  broadcast write enable
- o_s_sel  out  DATA_W/8  broadcast byte enables
- o_s_addr  out  ADDR_W  broadcast address, full address passed through
- o_s_wdata  out  DATA_W  broadcast write data
- i_s_rdata  in  N_SLAVES*DATA_W  slave k read data occupies bits [k*DATA_W +: DATA_W]
- i_s_ack  in  N_SLAVES  per-slave completion strobe

Behaviour:
- Clock and reset: single clock i_clk. Reset is synchronous, active-low on i_rst_n, sampled on the rising edge.
- Reset values:
  - state=IDLE; all registered request fields 0.
  - o_rdata=0, o_bus_err=0, o_err_addr=0, o_s_ce=0, o_s_we=0, o_s_sel=0, o_s_addr=0, o_s_wdata=0.
  - timeout counter=0.
- FSM states: IDLE, ACCESS, DONE.
- Stall: o_stall = (IDLE & i_ce) | ACCESS, combinational. DONE always drives o_stall=0.
- IDLE:
  - If i_ce is low, stay in IDLE.
  - If i_ce is high, decode idx = i_addr[SEL_MSB:SEL_LSB] and latch we/sel/addr/wdata into the slave-side registers.
  - idx < N_SLAVES: set o_s_ce = 1<<idx and go to ACCESS.
  - idx >= N_SLAVES: o_s_ce stays 0; go to DONE with o_bus_err=1, o_err_addr=i_addr; o_rdata is unchanged.
- ACCESS:
  - Hold o_s_ce and the broadcast fields stable.
  - Acks from non-selected slaves are ignored.
  - On i_s_ack[idx]=1: clear o_s_ce next edge and go to DONE.
  - On a read, load o_rdata from slave idx's slice of i_s_rdata. On a write, hold o_rdata.
  - An ack in the first ACCESS cycle is legal.
- DONE:
  - One cycle; o_stall=0, so the core consumes o_rdata and advances.
  - i_ce is ignored in this cycle, since it is still the completed request.
  - Next state IDLE. o_bus_err clears on leaving DONE.
- Latency: minimum 2 stall cycles (IDLE request, ACCESS with immediate ack), then DONE. Each slave wait cycle adds 1.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE.
- o_err_addr holds until the next error or reset.
- Reset mid-ACCESS: the transaction is abandoned; o_s_ce=0 and state=IDLE after the reset edge, with no error flagged.

Optional Feature:
- Macro: SOPC_DATA_BUS_TIMEOUT_EN.
- Defined:
  - An ACCESS-cycle counter starts at 0 on entry and increments each cycle without ack.
  - On reaching TIMEOUT-1 with no ack, go to DONE with o_bus_err=1, o_err_addr=latched addr, o_rdata=0 (reads); o_s_ce clears.
  - An ack arriving in that same cycle wins: normal completion, no error.
- Undefined: no counter; ACCESS waits for ack indefinitely.

Test Plan:
- Read slave 0, addr 0x0000_0010, ack in the first ACCESS cycle, rdata 0x1234_5678 -> o_stall high 2 cycles; o_s_ce=4'b0001 for 1 cycle; o_rdata=0x1234_5678 in DONE; o_bus_err=0.
- Write slave 2, addr 0x2000_0004, sel 4'b0011, wdata 0xAABB_CCDD, ack after 3 wait cycles -> o_s_ce=4'b0100 for 4 cycles; broadcast fields stable; o_rdata unchanged; o_stall high 5 cycles.
- Read addr 0x5000_0000 (idx 5 >= 4) -> o_s_ce stays 0; o_bus_err pulses 1 cycle; o_err_addr=0x5000_0000; o_stall high 1 cycle.
- Stray i_s_ack[3] during a slave-1 access, real ack 2 cycles later -> stray ack ignored; o_rdata from slave 1 only.
- i_rst_n low during ACCESS to slave 1 -> next edge: o_s_ce=0, state IDLE, o_rdata=0, no o_bus_err; a fresh request afterwards completes normally.
- With SOPC_DATA_BUS_TIMEOUT_EN, TIMEOUT=16, slave never acks -> DONE after 16 ACCESS cycles; o_bus_err=1; o_rdata=0. Without the macro, o_stall stays high.
